// File: rtl/frame_line_fetcher.sv
// Framed UART line loader: hunts for a sync byte, assembles one machine line
// into shadow registers, validates its XOR checksum, and commits it to the
// output registers behind a valid/ready handshake.

module uart_rx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_strobe,
  output logic [7:0] rx_byte
);
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = (CLKS_PER_BIT / 2) - 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t       st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            strobe_q, strobe_d;
  logic [1:0]      sync_q, sync_d;
  logic            rx_s;

  assign rx_s      = sync_q[1];
  assign rx_strobe = strobe_q;
  assign rx_byte   = sh_q;

  // Bit-timing state machine: confirm start at mid-bit, sample data mid-bit, strobe at mid-stop.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    strobe_d = 1'b0;
    sync_d   = {sync_q[0], rx};
    case (st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx_s) st_d = R_START;
      end
      R_START: begin
        if (32'(cnt_q) >= HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (32'(cnt_q) == CLKS_PER_BIT - 1) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = R_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (32'(cnt_q) == CLKS_PER_BIT - 1) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          st_d     = R_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: st_d = R_IDLE;
    endcase
  end

  // Receiver state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= R_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      strobe_q <= 1'b0;
      sync_q   <= 2'b11;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      strobe_q <= strobe_d;
      sync_q   <= sync_d;
    end
  end
endmodule

module frame_line_fetcher #(
  parameter int          CLKS_PER_BIT     = 10416,
  parameter int          MACHINE_COUNT    = 10,
  parameter int          MAX_BUTTON_COUNT = 13,
  parameter int          BITS_PER_JOLTAGE = 9,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
  parameter int          TIMEOUT_CLKS     = 208320
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        uart_input,
  output logic                                        line_valid,
  input  logic                                        line_ready,
  output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]       button_count,
  output logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]   flattened_buttons,
  output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]   flattened_machines,
  output logic                                        frame_error,
  output logic [1:0]                                  error_code
);
  localparam int BPB  = (MACHINE_COUNT + 7) / 8;
  localparam int BPJ  = (BITS_PER_JOLTAGE + 7) / 8;
  localparam int CW   = $clog2(MAX_BUTTON_COUNT + 1);
  localparam int IMAX = (MAX_BUTTON_COUNT > MACHINE_COUNT) ? MAX_BUTTON_COUNT : MACHINE_COUNT;
  localparam int IW   = $clog2(IMAX + 1);
  localparam int BMAX = (BPB > BPJ) ? BPB : BPJ;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {HUNT, COUNT, BUTTONS, JOLT, CHECK} state_t;

  logic       rx_stb;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_input),
    .rx_strobe (rx_stb),
    .rx_byte   (rx_byte)
  );

  state_t                                         state_q, state_d;
  logic [MAX_BUTTON_COUNT-1:0][MACHINE_COUNT-1:0] btn_sh_q, btn_sh_d;
  logic [MACHINE_COUNT-1:0][BITS_PER_JOLTAGE-1:0] jolt_sh_q, jolt_sh_d;
  logic [CW-1:0]                                  cnt_sh_q, cnt_sh_d;
  logic [7:0]                                     csum_q, csum_d;
  logic [IW-1:0]                                  item_q, item_d;
  logic [BW-1:0]                                  byte_q, byte_d;
  logic [TW-1:0]                                  to_q, to_d;
  logic                                           line_valid_q, line_valid_d;
  logic [CW-1:0]                                  button_count_q, button_count_d;
  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]      flat_btn_q, flat_btn_d;
  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]      flat_m_q, flat_m_d;
  logic                                           frame_error_q, frame_error_d;
  logic [1:0]                                     error_code_q, error_code_d;
  logic                                           rej;
  logic [1:0]                                     rej_code;

  assign line_valid         = line_valid_q;
  assign button_count       = button_count_q;
  assign flattened_buttons  = flat_btn_q;
  assign flattened_machines = flat_m_q;
  assign frame_error        = frame_error_q;
  assign error_code         = error_code_q;

  // Frame parser, validation, commit and handshake next-state logic.
  always_comb begin
    state_d        = state_q;
    btn_sh_d       = btn_sh_q;
    jolt_sh_d      = jolt_sh_q;
    cnt_sh_d       = cnt_sh_q;
    csum_d         = csum_q;
    item_d         = item_q;
    byte_d         = byte_q;
    line_valid_d   = line_valid_q;
    button_count_d = button_count_q;
    flat_btn_d     = flat_btn_q;
    flat_m_d       = flat_m_q;
    frame_error_d  = 1'b0;
    error_code_d   = error_code_q;
    rej            = 1'b0;
    rej_code       = '0;

    if (line_valid_q && line_ready) line_valid_d = 1'b0;
    if (state_q == HUNT || rx_stb) to_d = '0;
    else                           to_d = to_q + TW'(1);

    case (state_q)
      HUNT: begin
        if (rx_stb && rx_byte == SYNC_BYTE) begin
          btn_sh_d  = '0;
          jolt_sh_d = '0;
          cnt_sh_d  = '0;
          csum_d    = '0;
          item_d    = '0;
          byte_d    = '0;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        if (rx_stb) begin
          csum_d = csum_q ^ rx_byte;
          if (rx_byte == 8'd0 || 32'(rx_byte) > MAX_BUTTON_COUNT) begin
            rej      = 1'b1;
            rej_code = 2'd1;
          end else begin
            cnt_sh_d = rx_byte[CW-1:0];
            state_d  = BUTTONS;
          end
        end
      end
      BUTTONS: begin
        if (rx_stb) begin
          csum_d = csum_q ^ rx_byte;
          // Each field bit is taken from the byte that carries it; bits beyond the field are dropped.
          for (int unsigned i = 0; i < MAX_BUTTON_COUNT; i++)
            for (int unsigned b = 0; b < MACHINE_COUNT; b++)
              if (IW'(i) == item_q && BW'(b / 8) == byte_q)
                btn_sh_d[i][b] = rx_byte[b % 8];
          if (32'(byte_q) == BPB - 1) begin
            byte_d = '0;
            if (32'(item_q) + 1 == 32'(cnt_sh_q)) begin
              item_d  = '0;
              state_d = JOLT;
            end else begin
              item_d = item_q + IW'(1);
            end
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end
      JOLT: begin
        if (rx_stb) begin
          csum_d = csum_q ^ rx_byte;
          for (int unsigned m = 0; m < MACHINE_COUNT; m++)
            for (int unsigned b = 0; b < BITS_PER_JOLTAGE; b++)
              if (IW'(m) == item_q && BW'(b / 8) == byte_q)
                jolt_sh_d[m][b] = rx_byte[b % 8];
          if (32'(byte_q) == BPJ - 1) begin
            byte_d = '0;
            if (32'(item_q) == MACHINE_COUNT - 1) begin
              item_d  = '0;
              state_d = CHECK;
            end else begin
              item_d = item_q + IW'(1);
            end
          end else begin
            byte_d = byte_q + BW'(1);
          end
        end
      end
      CHECK: begin
        if (rx_stb) begin
          if (rx_byte != csum_q) begin
            rej      = 1'b1;
            rej_code = 2'd0;
          end else if (line_valid_q && !line_ready) begin
            rej      = 1'b1;
            rej_code = 2'd3;
          end else begin
            // A commit coinciding with a handshake keeps line_valid high for the new line.
            line_valid_d   = 1'b1;
            button_count_d = cnt_sh_q;
            for (int unsigned i = 0; i < MAX_BUTTON_COUNT; i++)
              flat_btn_d[i*MACHINE_COUNT +: MACHINE_COUNT] = btn_sh_q[i];
            for (int unsigned m = 0; m < MACHINE_COUNT; m++)
              flat_m_d[m*BITS_PER_JOLTAGE +: BITS_PER_JOLTAGE] = jolt_sh_q[m];
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (state_q != HUNT && !rx_stb && 32'(to_q) == TIMEOUT_CLKS - 1) begin
      rej      = 1'b1;
      rej_code = 2'd2;
    end

    if (rej) begin
      frame_error_d = 1'b1;
      error_code_d  = rej_code;
      state_d       = HUNT;
      btn_sh_d      = '0;
      jolt_sh_d     = '0;
      cnt_sh_d      = '0;
      csum_d        = '0;
      item_d        = '0;
      byte_d        = '0;
      to_d          = '0;
    end
  end

  // Parser, shadow and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HUNT;
      btn_sh_q       <= '0;
      jolt_sh_q      <= '0;
      cnt_sh_q       <= '0;
      csum_q         <= '0;
      item_q         <= '0;
      byte_q         <= '0;
      to_q           <= '0;
      line_valid_q   <= 1'b0;
      button_count_q <= '0;
      flat_btn_q     <= '0;
      flat_m_q       <= '0;
      frame_error_q  <= 1'b0;
      error_code_q   <= '0;
    end else begin
      state_q        <= state_d;
      btn_sh_q       <= btn_sh_d;
      jolt_sh_q      <= jolt_sh_d;
      cnt_sh_q       <= cnt_sh_d;
      csum_q         <= csum_d;
      item_q         <= item_d;
      byte_q         <= byte_d;
      to_q           <= to_d;
      line_valid_q   <= line_valid_d;
      button_count_q <= button_count_d;
      flat_btn_q     <= flat_btn_d;
      flat_m_q       <= flat_m_d;
      frame_error_q  <= frame_error_d;
      error_code_q   <= error_code_d;
    end
  end
endmodule

// File: tb/tb_frame_line_fetcher.sv
// Testbench for frame_line_fetcher: serialises frames onto the UART line,
// scoreboards expected commit/reject events, and checks held output state.

module tb_frame_line_fetcher;
  localparam int MC  = 4;
  localparam int MBC = 3;
  localparam int BJ  = 9;
  localparam int CPB = 4;
  localparam int TO  = 200;

  logic             clk = 1'b0;
  logic             reset;
  logic             uart_input;
  logic             line_ready;
  logic             line_valid;
  logic [1:0]       button_count;
  logic [MC*MBC-1:0] flattened_buttons;
  logic [MC*BJ-1:0]  flattened_machines;
  logic             frame_error;
  logic [1:0]       error_code;

  always #5 clk = ~clk;

  frame_line_fetcher #(
    .CLKS_PER_BIT     (CPB),
    .MACHINE_COUNT    (MC),
    .MAX_BUTTON_COUNT (MBC),
    .BITS_PER_JOLTAGE (BJ),
    .SYNC_BYTE        (8'hA5),
    .TIMEOUT_CLKS     (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .uart_input         (uart_input),
    .line_valid         (line_valid),
    .line_ready         (line_ready),
    .button_count       (button_count),
    .flattened_buttons  (flattened_buttons),
    .flattened_machines (flattened_machines),
    .frame_error        (frame_error),
    .error_code         (error_code)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [1:0]  cnt;
    logic [11:0] btn;
    logic [35:0] mach;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ev_cnt = 0;
  int   exp_ev = 0;

  // Bench model of the committed line and last rejection code.
  bit          cur_valid = 0;
  logic [1:0]  cur_cnt   = '0;
  logic [11:0] cur_btn   = '0;
  logic [35:0] cur_mach  = '0;
  logic [1:0]  cur_code  = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Event monitor: every reject pulse or commit pops one scoreboard entry.
  initial begin
    bit   prev_valid;
    exp_t e;
    prev_valid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 0;
      end else begin
        if (frame_error || (line_valid && !prev_valid)) begin
          ev_cnt++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got frame_error=%0b code=%0d line_valid=%0b, expected no event",
                     frame_error, error_code, line_valid);
          end else begin
            e = sb_q.pop_front();
            chk("event_is_error", 64'(frame_error), 64'(e.is_err));
            if (e.is_err) begin
              chk("error_code", 64'(error_code), 64'(e.code));
              cur_code = e.code;
            end else begin
              chk("commit_button_count", 64'(button_count), 64'(e.cnt));
              chk("commit_buttons", 64'(flattened_buttons), 64'(e.btn));
              chk("commit_machines", 64'(flattened_machines), 64'(e.mach));
              cur_valid = 1;
              cur_cnt   = e.cnt;
              cur_btn   = e.btn;
              cur_mach  = e.mach;
            end
          end
        end
        prev_valid = line_valid;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    uart_input = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_input = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_input = 1'b1;
    repeat (3*CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bq_t q);
    for (int j = 0; j < q.size(); j++) send_byte(q[j]);
  endtask

  task automatic expect_event(input exp_t e);
    sb_q.push_back(e);
    exp_ev++;
  endtask

  task automatic wait_events();
    for (int i = 0; i < 400 && ev_cnt < exp_ev; i++) @(negedge clk);
    if (ev_cnt < exp_ev) begin
      checks++;
      errors++;
      $display("FAIL event_timeout: got %0d events, expected %0d", ev_cnt, exp_ev);
      sb_q.delete();
      ev_cnt = exp_ev;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_line_valid"}, 64'(line_valid), 64'(cur_valid));
    chk({tag, "_button_count"}, 64'(button_count), 64'(cur_cnt));
    chk({tag, "_buttons"}, 64'(flattened_buttons), 64'(cur_btn));
    chk({tag, "_machines"}, 64'(flattened_machines), 64'(cur_mach));
    chk({tag, "_error_code"}, 64'(error_code), 64'(cur_code));
  endtask

  task automatic drain();
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
    chk("handshake_drop", 64'(line_valid), 64'd0);
    cur_valid = 0;
    @(negedge clk);
  endtask

  bq_t  vbytes [4];
  exp_t vexp   [4];

  initial begin
    bq_t  f1, f4, part;
    exp_t e_f1, e_f4, e_err;

    reset      = 1'b1;
    uart_input = 1'b1;
    line_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_frame_error", 64'(frame_error), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    f1 = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h03, 8'h0C, 8'h10, 8'h00,
           8'h20, 8'h00, 8'h30, 8'h00, 8'h41, 8'h01, 8'h4D};
    f4 = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h04, 8'hFF, 8'h01, 8'h00,
           8'h00, 8'hAA, 8'h00, 8'h55, 8'h01, 8'h04};
    e_f1 = '{is_err: 0, code: 2'd0, cnt: 2'd2, btn: 12'h0C3,
             mach: {9'h141, 9'h030, 9'h020, 9'h010}};
    e_f4 = '{is_err: 0, code: 2'd0, cnt: 2'd3, btn: 12'h421,
             mach: {9'h155, 9'h0AA, 9'h000, 9'h1FF}};
    e_err = '{is_err: 1, code: 2'd0, cnt: 2'd0, btn: '0, mach: '0};

    // Table: bad checksum from reset, bad count, good frame, second good frame.
    vbytes[0] = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h03, 8'h0C, 8'h10, 8'h00,
                  8'h20, 8'h00, 8'h30, 8'h00, 8'h41, 8'h01, 8'h4C};
    vexp[0]   = e_err;
    vbytes[1] = '{8'hA5, 8'h04};
    vexp[1]   = e_err;
    vexp[1].code = 2'd1;
    vbytes[2] = f1;
    vexp[2]   = e_f1;
    vbytes[3] = f4;
    vexp[3]   = e_f4;

    for (int v = 0; v < 4; v++) begin
      expect_event(vexp[v]);
      send_frame(vbytes[v]);
      wait_events();
      repeat (2) @(negedge clk);
      check_state($sformatf("vec%0d", v));
      if (cur_valid) drain();
    end

    // Timeout mid-frame, then a clean frame commits.
    e_err.code = 2'd2;
    expect_event(e_err);
    part = '{8'hA5, 8'h02, 8'h03};
    send_frame(part);
    repeat (250) @(negedge clk);
    wait_events();
    check_state("timeout");
    expect_event(e_f1);
    send_frame(f1);
    wait_events();
    repeat (2) @(negedge clk);
    check_state("after_timeout");

    // Overflow: second valid frame while the first is still pending.
    e_err.code = 2'd3;
    expect_event(e_err);
    send_frame(f4);
    wait_events();
    repeat (2) @(negedge clk);
    check_state("overflow");
    drain();

    // Reset in the middle of the button bytes.
    part = '{8'hA5, 8'h03, 8'h01};
    send_frame(part);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cur_valid = 0;
    cur_cnt   = '0;
    cur_btn   = '0;
    cur_mach  = '0;
    cur_code  = '0;
    check_state("midframe_reset");
    reset = 1'b0;
    @(negedge clk);
    expect_event(e_f1);
    send_frame(f1);
    wait_events();
    repeat (2) @(negedge clk);
    check_state("after_reset");

    repeat (TO + 20) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("event_count", 64'(ev_cnt), 64'(exp_ev));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
